imem_loader: RTL and testbench

- Write-side counterpart of the instruction fetch path: fills the 256 x 16-bit instruction memory from a byte stream (debug UART or SPI bridge) before the core runs.
- Receives a length-prefixed, checksummed byte stream over a valid/ready handshake.
- Assembles little-endian 16-bit words and issues single-cycle word writes.
- Holds the core (deasserts PC advance) until a load completes with a correct checksum.

---
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory loader: fills the 256 x 16-bit imem from a length-prefixed,
// XOR-checksummed byte stream and holds the core until a load passes its checksum.
module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [15:0]   wdata,
  output logic          core_hold,
  output logic          done,
  output logic          err
);

  // state   | meaning
  // IDLE    | after reset, waiting for start
  // CNT_LO  | expecting word count low byte
  // CNT_HI  | expecting word count high byte, range-checks N
  // DATA_LO | expecting low byte of the next word
  // DATA_HI | expecting high byte; the word is written the next cycle
  // CSUM    | expecting the XOR checksum byte
  // DONE    | load good, core released
  // ERR     | bad length or checksum, core held
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CNT_LO  = 3'd1;
  localparam logic [2:0] S_CNT_HI  = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_DATA_HI = 3'd4;
  localparam logic [2:0] S_CSUM    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERR     = 3'd7;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  logic [2:0]  state, state_nxt;
  logic [7:0]  cnt_lo;
  logic [7:0]  lo_byte;
  logic [7:0]  csum;
  logic [AW:0] cnt;
  logic [AW:0] idx;
  logic [AW:0] idx_inc;
  logic [15:0] n_full;
  logic        xfer;
  logic        n_bad;
  logic        idle_like;

  assign xfer      = s_valid && s_ready;
  assign n_full    = {s_data, cnt_lo};
  assign n_bad     = (n_full == 16'd0) || ({1'b0, n_full} > DEPTH_W);
  assign idx_inc   = idx + 1'b1;
  assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_CNT_LO;
      S_CNT_LO:  if (xfer) state_nxt = S_CNT_HI;
      S_CNT_HI:  if (xfer) state_nxt = n_bad ? S_ERR : S_DATA_LO;
      S_DATA_LO: if (xfer) state_nxt = S_DATA_HI;
      S_DATA_HI: if (xfer) state_nxt = (idx_inc == cnt) ? S_CSUM : S_DATA_LO;
      S_CSUM:    if (xfer) state_nxt = (s_data == csum) ? S_DONE : S_ERR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered copies of the next state so they change
  // together with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      s_ready   <= 1'b0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      s_ready   <= (state_nxt == S_CNT_LO) || (state_nxt == S_CNT_HI) ||
                   (state_nxt == S_DATA_LO) || (state_nxt == S_DATA_HI) ||
                   (state_nxt == S_CSUM);
      core_hold <= (state_nxt != S_DONE);
      done      <= (state_nxt == S_DONE);
      err       <= (state_nxt == S_ERR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lo  <= '0;
      cnt     <= '0;
      lo_byte <= '0;
      csum    <= '0;
      idx     <= '0;
      we      <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
    end else begin
      we <= 1'b0;
      if (idle_like && start) begin
        idx  <= '0;
        csum <= '0;
      end
      if (xfer) begin
        case (state)
          S_CNT_LO:  cnt_lo <= s_data;
          S_CNT_HI:  cnt    <= n_full[AW:0];
          S_DATA_LO: begin
            lo_byte <= s_data;
            csum    <= csum ^ s_data;
          end
          S_DATA_HI: begin
            csum  <= csum ^ s_data;
            we    <= 1'b1;
            waddr <= idx[AW-1:0];
            wdata <= {s_data, lo_byte};
            idx   <= idx_inc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven load scenarios plus
// hand-written multi-cycle sequences, with a write scoreboard.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        we;
  logic [7:0]  waddr;
  logic [15:0] wdata;
  logic        core_hold;
  logic        done;
  logic        err;

  imem_loader #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .core_hold(core_hold), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int wcount = 0;
  logic [23:0] exp_q[$];
  logic [15:0] pay [0:255];
  logic        prev_we = 1'b0;
  logic [7:0]  prev_addr = '0;

  typedef struct {
    logic [15:0]       n;
    int                nsend;
    logic [3:0][15:0]  w;
    logic [7:0]        cdelta;
    bit                exp_done;
    bit                exp_err;
    int                exp_w;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitor: every we pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        logic [23:0] e;
        wcount++;
        if (prev_we && waddr == prev_addr) begin
          checks++; fails++;
          $display("FAIL we_repeat: addr %0h written on consecutive cycles", waddr);
        end
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL we_unexpected: got addr %0h data %0h expected no write", waddr, wdata);
        end else begin
          e = exp_q.pop_front();
          if ({waddr, wdata} !== e) begin
            fails++;
            $display("FAIL we_write: got addr %0h data %0h expected addr %0h data %0h",
                     waddr, wdata, e[23:16], e[15:0]);
          end
        end
      end
      prev_we   = we;
      prev_addr = waddr;
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int bub);
    int t;
    while ($urandom_range(99) < bub) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    while (!s_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      checks++; fails++;
      $display("FAIL s_ready_timeout: got s_ready=0 expected 1 within 300 cycles");
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_word(input int addr, input logic [15:0] w, input int bub);
    send_byte(w[7:0], bub);
    exp_q.push_back({8'(addr), w});
    send_byte(w[15:8], bub);
  endtask

  task automatic send_stream(input logic [15:0] n, input int nsend,
                             input logic [7:0] cdelta, input int bub);
    logic [7:0] cs;
    cs = 8'h00;
    send_byte(n[7:0], bub);
    send_byte(n[15:8], bub);
    if (n == 16'd0 || n > 16'd256) return;
    for (int i = 0; i < nsend; i++) begin
      cs = cs ^ pay[i][7:0] ^ pay[i][15:8];
      send_word(i, pay[i], bub);
    end
    send_byte(cs ^ cdelta, bub);
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!(done || err) && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
  endtask

  task automatic check_end(input string tag, input bit e_done, input bit e_err, input int e_w);
    chk({tag, "_done"},      32'(done),      32'(e_done));
    chk({tag, "_err"},       32'(err),       32'(e_err));
    chk({tag, "_core_hold"}, 32'(core_hold), 32'(!e_done));
    chk({tag, "_s_ready"},   32'(s_ready),   32'd0);
    chk({tag, "_wcount"},    32'(wcount),    32'(e_w));
    chk({tag, "_pending"},   32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'd2,   2, {16'h0, 16'h0, 16'hABCD, 16'h1234}, 8'h00, 1'b1, 1'b0, 2};
    vecs[1] = '{16'd2,   2, {16'h0, 16'h0, 16'hABCD, 16'h1234}, 8'h01, 1'b0, 1'b1, 2};
    vecs[2] = '{16'd0,   0, {16'h0, 16'h0, 16'h0, 16'h0},       8'h00, 1'b0, 1'b1, 0};
    vecs[3] = '{16'd257, 0, {16'h0, 16'h0, 16'h0, 16'h0},       8'h00, 1'b0, 1'b1, 0};
    vecs[4] = '{16'd1,   1, {16'h0, 16'h0, 16'h0, 16'hBEEF},    8'h00, 1'b1, 1'b0, 1};
    vecs[5] = '{16'd3,   3, {16'h0, 16'h0F0F, 16'h8001, 16'h7E55}, 8'hFF, 1'b0, 1'b1, 3};

    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_s_ready",   32'(s_ready),   32'd0);
    chk("rst_we",        32'(we),        32'd0);
    chk("rst_core_hold", 32'(core_hold), 32'd1);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_err",       32'(err),       32'd0);
    chk("rst_waddr",     32'(waddr),     32'd0);
    chk("rst_wdata",     32'(wdata),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) pay[i] = vecs[v].w[i];
      wcount = 0;
      pulse_start();
      chk("start_clears_done", 32'(done), 32'd0);
      chk("start_clears_err",  32'(err),  32'd0);
      chk("start_hold",        32'(core_hold), 32'd1);
      send_stream(vecs[v].n, vecs[v].nsend, vecs[v].cdelta, (v == 4) ? 40 : 0);
      wait_end();
      check_end($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_w);
    end

    // Full-depth load with random bubbles.
    for (int i = 0; i < 256; i++) pay[i] = {8'(i), ~8'(i)};
    wcount = 0;
    pulse_start();
    send_stream(16'd256, 256, 8'h00, 30);
    wait_end();
    check_end("full256", 1'b1, 1'b0, 256);

    // Asynchronous reset after word 3 of a 10-word load.
    for (int i = 0; i < 10; i++) pay[i] = 16'h1000 + 16'(i);
    wcount = 0;
    pulse_start();
    send_byte(8'd10, 0);
    send_byte(8'd0, 0);
    for (int i = 0; i < 4; i++) send_word(i, pay[i], 0);
    @(negedge clk);
    chk("midrst_wcount", 32'(wcount), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("midrst_s_ready",   32'(s_ready),   32'd0);
    chk("midrst_we",        32'(we),        32'd0);
    chk("midrst_core_hold", 32'(core_hold), 32'd1);
    chk("midrst_done",      32'(done),      32'd0);
    chk("midrst_err",       32'(err),       32'd0);
    chk("midrst_waddr",     32'(waddr),     32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pay[0] = 16'h5AC3;
    wcount = 0;
    pulse_start();
    send_stream(16'd1, 1, 8'h00, 0);
    wait_end();
    check_end("after_rst", 1'b1, 1'b0, 1);

    // start pulses during DATA_LO must be ignored.
    wcount = 0;
    pulse_start();
    send_byte(8'd2, 0);
    send_byte(8'd0, 0);
    pulse_start();
    send_word(0, 16'h1234, 0);
    pulse_start();
    send_word(1, 16'hABCD, 0);
    chk("ign_start_ready", 32'(s_ready), 32'd1);
    send_byte(8'h40, 0);
    wait_end();
    check_end("ign_start", 1'b1, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
